// File: rtl/alu_32mul_seq_pkg.sv
// Shared ALU definitions: operand width, iteration counter width and the
// multiply/divide state encoding reused by the HI/LO write-back path.
package alu_32mul_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_32mul_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the {A, Q, q_1} chain.
module alu_32mul_seq_booth_step
  import alu_32mul_seq_pkg::*;
(
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] sum_s;

  // Booth add/sub selection followed by the sign-replicating shift
  always_comb begin
    sum_s = a_i;
    case ({q_i[0], q1_i})
      2'b01:   sum_s = a_i + m_i;
      2'b10:   sum_s = a_i - m_i;
      default: sum_s = a_i;
    endcase
    a_o  = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_o  = {sum_s[0], q_i[WIDTH-1:1]};
    q1_o = q_i[0];
  end

endmodule

// File: rtl/alu_32mul_seq.sv
// Sequential signed WIDTHxWIDTH multiplier, one Booth iteration per clock,
// with a start/busy/done handshake and a {hi, lo} packed registered result.
module alu_32mul_seq
  import alu_32mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  state_e             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     step_a_s;
  logic [WIDTH-1:0]   step_q_s;
  logic               step_q1_s;

  alu_32mul_seq_booth_step u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a_s),
    .q_o  (step_q_s),
    .q1_o (step_q1_s)
  );

  // Next-state, datapath and output-register inputs
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = step_a_s;
        q_d   = step_q_s;
        q1_d  = step_q1_s;
        cnt_d = cnt_q + CNT_W'(1);
        // Result is taken from the post-shift values of the final iteration
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = {step_a_s[WIDTH-1:0], step_q_s};
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
